// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after 'last', wrapping at N.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(last) + k) % N);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx byte port between
// NUM_REQ sources, with an inter-message gap and a mid-message stall timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 3,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*8-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_valid,
    output logic [7:0]                   tx_data,
    input  logic                         tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         abort
);

    localparam int unsigned GID_W = $clog2(NUM_REQ);
    localparam bit STALL_EN = (STALL_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 32'd0);
    localparam logic [CNT_W-1:0] STALL_LAST =
        CNT_W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 32'd0);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [GID_W-1:0]  pick_id;
    logic              pick_found;
    logic              sel_valid;
    logic              sel_last;
    logic [BYTE_W-1:0] sel_data;
    logic              load_c;
    logic              stall_hit_c;
    logic              gap_done_c;
    logic [CNT_W-1:0]  cnt;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (GID_W)
    ) u_pick (
        .req    (req_valid),
        .last   (grant_id),
        .winner (pick_id),
        .found  (pick_found)
    );

    // Current owner's request lines
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (GID_W'(i) == grant_id) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (|req_valid) state_nx = ARB;
            ARB:  state_nx = pick_found ? SEND : IDLE;
            SEND: if ((load_c && sel_last) || stall_hit_c) state_nx = GAP;
            GAP:  if (gap_done_c) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake decode; the output stage may accept whenever it is empty or draining
    always_comb begin
        req_ready   = '0;
        load_c      = 1'b0;
        stall_hit_c = 1'b0;
        gap_done_c  = 1'b0;
        busy        = (state != IDLE);
        if (state == SEND) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (GID_W'(i) == grant_id) req_ready[i] = !tx_valid || tx_ready;
            end
            load_c      = sel_valid && (!tx_valid || tx_ready);
            stall_hit_c = STALL_EN && !sel_valid && (cnt == STALL_LAST);
        end
        if (state == GAP) begin
            gap_done_c = !tx_valid && ((GAP_CYCLES == 0) || (cnt == GAP_LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            grant_id <= GID_W'(NUM_REQ - 1);
            cnt      <= '0;
            abort    <= 1'b0;
        end else begin
            abort <= stall_hit_c;

            if (load_c) begin
                tx_valid <= 1'b1;
                tx_data  <= sel_data;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end

            if (state == ARB && pick_found) grant_id <= pick_id;

            // One counter serves as stall timer in SEND and gap timer in GAP
            case (state)
                SEND: begin
                    if (load_c || stall_hit_c) cnt <= '0;
                    else if (!sel_valid)       cnt <= cnt + 1'b1;
                end
                GAP: begin
                    if (gap_done_c)     cnt <= '0;
                    else if (!tx_valid) cnt <= cnt + 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed timing cases plus randomized traffic against a
// message-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NR  = 3;
    localparam int GAP = 16;
    localparam int STO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            abort;

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .GAP_CYCLES    (GAP),
        .STALL_TIMEOUT (STO),
        .CNT_W         (11)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Pending bytes per source, and the expected UART byte stream with owner
    logic [7:0] q_data [NR][$];
    bit         q_last [NR][$];
    logic [7:0] exp_data[$];
    int         exp_src[$];
    int         model_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic v, input logic [7:0] d, input logic l);
        req_valid[s]       = v;
        req_data[s*8 +: 8] = d;
        req_last[s]        = l;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        to_drive();
        to_drive();
        to_neg();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_abort", abort, 0);
        check("rst_grant_id", grant_id, NR - 1);
        check("rst_req_ready", req_ready, 0);
        to_drive();
        reset      = 1'b0;
        model_last = NR - 1;
    endtask

    task automatic send_byte(input int s, input logic [7:0] d, input logic l);
        bit ok = 0;
        set_src(s, 1'b1, d, l);
        for (int k = 0; k < 200; k++) begin
            to_neg();
            if (req_ready[s]) begin
                ok = 1;
                break;
            end
            to_drive();
        end
        check("send_byte_handshake", ok, 1);
        to_drive();
        req_valid[s] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            to_neg();
            if (!busy && !tx_valid) begin
                ok = 1;
                break;
            end
            to_drive();
        end
        check("reach_idle", ok, 1);
        to_drive();
    endtask

    task automatic add_msg(input int s, input int len);
        for (int j = 0; j < len; j++) begin
            q_data[s].push_back(8'($urandom));
            q_last[s].push_back(j == len - 1);
        end
    endtask

    // Whole messages granted round-robin among sources that still have one pending
    task automatic build_expected();
        int  ptr[NR];
        int  pick;
        int  c;
        bit  fin;
        for (int i = 0; i < NR; i++) ptr[i] = 0;
        while (1) begin
            pick = -1;
            for (int o = 1; o <= NR; o++) begin
                c = (model_last + o) % NR;
                if (pick < 0 && ptr[c] < q_data[c].size()) pick = c;
            end
            if (pick < 0) break;
            fin = 0;
            while (!fin) begin
                exp_data.push_back(q_data[pick][ptr[pick]]);
                exp_src.push_back(pick);
                fin = q_last[pick][ptr[pick]];
                ptr[pick]++;
            end
            model_last = pick;
        end
    endtask

    task automatic run_traffic(input bit rnd, input string name);
        bit            mid[NR];
        int            bub[NR];
        bit            done = 0;
        bit            hold;
        logic [NR-1:0] hs;
        for (int i = 0; i < NR; i++) begin
            mid[i] = 0;
            bub[i] = 0;
        end
        build_expected();
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                hold   = mid[i] && rnd && (bub[i] < 3) && ($urandom_range(0, 3) == 0);
                bub[i] = hold ? bub[i] + 1 : 0;
                if (q_data[i].size() > 0) set_src(i, !hold, q_data[i][0], q_last[i][0]);
                else set_src(i, 1'b0, 8'h00, 1'b0);
            end
            tx_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            to_neg();
            check({name, "_ready_onehot"}, ($countones(req_ready) <= 1), 1);
            if (tx_valid && !tx_ready) check({name, "_ready_in_bp"}, req_ready, 0);
            if (tx_valid && tx_ready) begin
                if (exp_data.size() > 0) begin
                    check({name, "_tx_data"}, tx_data, exp_data.pop_front());
                    check({name, "_grant_id"}, grant_id, exp_src.pop_front());
                end else begin
                    check({name, "_extra_byte"}, tx_valid, 0);
                end
            end
            hs = req_valid & req_ready;
            to_drive();
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) begin
                    mid[i] = !q_last[i][0];
                    void'(q_data[i].pop_front());
                    void'(q_last[i].pop_front());
                end
            end
            done = (exp_data.size() == 0);
            for (int i = 0; i < NR; i++) if (q_data[i].size() > 0) done = 0;
        end
        check({name, "_complete"}, done, 1);
        req_valid = '0;
        tx_ready  = 1'b1;
        wait_idle();
    endtask

    initial begin
        int gap_n;
        int abort_at;
        int abort_n;

        // Single message: timing of ready, bytes and gap
        do_reset();
        set_src(0, 1'b1, 8'h48, 1'b0);
        to_neg();
        check("n0_busy", busy, 0);
        to_drive();
        to_neg();
        check("n1_busy", busy, 1);
        check("n1_ready", req_ready, 0);
        to_drive();
        to_neg();
        check("n2_ready", req_ready, 3'b001);
        check("n2_tx_valid", tx_valid, 0);
        to_drive();
        set_src(0, 1'b1, 8'h49, 1'b1);
        to_neg();
        check("n3_tx_valid", tx_valid, 1);
        check("n3_tx_data", tx_data, 8'h48);
        check("n3_ready", req_ready, 3'b001);
        to_drive();
        set_src(0, 1'b0, 8'h00, 1'b0);
        to_neg();
        check("n4_tx_valid", tx_valid, 1);
        check("n4_tx_data", tx_data, 8'h49);
        check("n4_grant_id", grant_id, 0);
        gap_n = 0;
        for (int k = 0; k < 40; k++) begin
            to_drive();
            to_neg();
            if (!busy) break;
            if (!tx_valid) gap_n++;
        end
        check("gap_cycles", gap_n, GAP);
        check("gap_end_busy", busy, 0);
        to_drive();

        // Contention from reset, then wrap back to source 0
        do_reset();
        for (int s = 0; s < NR; s++) add_msg(s, 3);
        run_traffic(1'b0, "contention");
        add_msg(0, 2);
        add_msg(2, 2);
        run_traffic(1'b0, "wrap");

        // Backpressure holds the output stage; next byte loads as tx_ready rises
        do_reset();
        send_byte(1, 8'hA1, 1'b0);
        tx_ready = 1'b0;
        set_src(1, 1'b1, 8'hA2, 1'b0);
        for (int k = 0; k < 50; k++) begin
            to_neg();
            check("bp_tx_valid", tx_valid, 1);
            check("bp_tx_data", tx_data, 8'hA1);
            check("bp_req_ready", req_ready, 0);
            to_drive();
        end
        tx_ready = 1'b1;
        to_neg();
        check("bp_resume_ready", req_ready, 3'b010);
        to_drive();
        set_src(1, 1'b1, 8'hA3, 1'b1);
        to_neg();
        check("bp_next_valid", tx_valid, 1);
        check("bp_next_data", tx_data, 8'hA2);
        to_drive();
        send_byte(1, 8'hA3, 1'b1);
        wait_idle();

        // Stall timeout revokes source 1, source 2 is granted next
        do_reset();
        send_byte(1, 8'h5A, 1'b0);
        set_src(2, 1'b1, 8'h77, 1'b1);
        abort_at = 0;
        abort_n  = 0;
        for (int j = 1; j <= 12; j++) begin
            to_neg();
            if (j == 1) check("stall_byte", tx_data, 8'h5A);
            if (abort) begin
                abort_n++;
                if (abort_at == 0) abort_at = j;
                check("abort_busy", busy, 1);
            end
            to_drive();
        end
        check("abort_cycle", abort_at, STO + 1);
        check("abort_width", abort_n, 1);
        for (int k = 0; k < 100; k++) begin
            to_neg();
            if (req_ready[2]) break;
            to_drive();
        end
        check("stall_next_grant", grant_id, 2);
        check("stall_next_ready", req_ready, 3'b100);
        to_drive();
        req_valid[2] = 1'b0;
        to_neg();
        check("stall_next_byte", tx_data, 8'h77);
        to_drive();
        wait_idle();

        // Reset while a byte is held in the output stage
        do_reset();
        tx_ready = 1'b0;
        set_src(0, 1'b1, 8'hC3, 1'b0);
        for (int k = 0; k < 20; k++) begin
            to_neg();
            if (req_ready[0]) break;
            to_drive();
        end
        to_drive();
        set_src(0, 1'b1, 8'hC4, 1'b0);
        to_neg();
        check("rs_pre_tx_valid", tx_valid, 1);
        check("rs_pre_ready", req_ready, 0);
        to_drive();
        reset = 1'b1;
        to_drive();
        reset = 1'b0;
        to_neg();
        check("rs_tx_valid", tx_valid, 0);
        check("rs_busy", busy, 0);
        check("rs_grant_id", grant_id, NR - 1);
        check("rs_req_ready", req_ready, 0);
        to_drive();
        req_valid = '0;
        tx_ready  = 1'b1;
        wait_idle();

        // Randomized traffic with bubbles and backpressure
        do_reset();
        for (int s = 0; s < NR; s++) begin
            repeat ($urandom_range(1, 3)) add_msg(s, $urandom_range(1, 4));
        end
        run_traffic(1'b1, "random_a");
        for (int s = 0; s < NR; s++) begin
            repeat ($urandom_range(0, 3)) add_msg(s, $urandom_range(1, 5));
        end
        run_traffic(1'b1, "random_b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
